// File: rtl/spi_master.sv
// Single chip-select SPI master: shifts one SPI_DATA_WIDTH-bit word out on MOSI (MSB first)
// while capturing the word returned on MISO. Every output is driven straight from a register.
module spi_master #(
    parameter int   SPI_DATA_WIDTH = 8,
    parameter int   CLK_DIV        = 4,
    parameter logic CPOL           = 1'b0,
    parameter logic CPHA           = 1'b0,
    parameter int   CS_IDLE_CYCLES = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [SPI_DATA_WIDTH-1:0] i_data,
    output logic [SPI_DATA_WIDTH-1:0] o_data,
    output logic                      o_done,
    output logic                      o_busy,
    output logic                      o_sclk,
    output logic                      o_mosi,
    input  logic                      i_miso,
    output logic                      o_cs_n
);

    localparam int W      = SPI_DATA_WIDTH;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * W + 1);
    localparam int GAP_W  = (CS_IDLE_CYCLES > 2) ? $clog2(CS_IDLE_CYCLES - 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * W);
    // The IDLE cycle that follows GAP still shows busy/cs_n high, so GAP itself is one cycle short.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_IDLE_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
    logic [EDGE_W-1:0]   edge_cnt_reg, edge_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [W-1:0]        tx_shift_reg, tx_shift_next;
    logic [W-1:0]        rx_shift_reg, rx_shift_next;
    logic [W-1:0]        data_reg, data_next;
    logic                sclk_reg, sclk_next;
    logic                mosi_reg, mosi_next;
    logic                cs_n_reg, cs_n_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                tick;
    logic [EDGE_W-1:0]   edge_k;

    assign tick   = (div_cnt_reg == DIV_LAST);
    assign edge_k = edge_cnt_reg + EDGE_W'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            data_reg     <= '0;
            sclk_reg     <= CPOL;
            mosi_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            data_reg     <= data_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            cs_n_reg     <= cs_n_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        data_next     = data_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        cs_n_next     = cs_n_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy_next = i_enable;
                cs_n_next = 1'b1;
                if (i_enable) begin
                    state_next    = LEAD;
                    cs_n_next     = 1'b0;
                    div_cnt_next  = '0;
                    edge_cnt_next = '0;
                    rx_shift_next = '0;
                    // CPHA=0 must present the MSB before the first (sampling) edge.
                    if (CPHA == 1'b0) begin
                        mosi_next     = i_data[W-1];
                        tx_shift_next = {i_data[W-2:0], 1'b0};
                    end else begin
                        mosi_next     = 1'b0;
                        tx_shift_next = i_data;
                    end
                end
            end

            LEAD, SHIFT: begin
                if (tick) begin
                    div_cnt_next  = '0;
                    edge_cnt_next = edge_k;
                    sclk_next     = ~sclk_reg;
                    if (edge_k[0]) begin
                        if (CPHA == 1'b0) begin
                            rx_shift_next = {rx_shift_reg[W-2:0], i_miso};
                        end else begin
                            mosi_next     = tx_shift_reg[W-1];
                            tx_shift_next = {tx_shift_reg[W-2:0], 1'b0};
                        end
                    end else begin
                        if (CPHA == 1'b1) begin
                            rx_shift_next = {rx_shift_reg[W-2:0], i_miso};
                        end else if (edge_k != EDGE_LAST) begin
                            mosi_next     = tx_shift_reg[W-1];
                            tx_shift_next = {tx_shift_reg[W-2:0], 1'b0};
                        end
                    end
                    if (state_reg == LEAD) begin
                        state_next = SHIFT;
                    end else if (edge_k == EDGE_LAST) begin
                        state_next = TRAIL;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end

            TRAIL: begin
                if (tick) begin
                    div_cnt_next = '0;
                    cs_n_next    = 1'b1;
                    done_next    = 1'b1;
                    data_next    = rx_shift_reg;
                    mosi_next    = 1'b0;
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end

            GAP: begin
                busy_next = 1'b1;
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data = data_reg;
    assign o_done = done_reg;
    assign o_busy = busy_reg;
    assign o_sclk = sclk_reg;
    assign o_mosi = mosi_reg;
    assign o_cs_n = cs_n_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a mode-0 instance (loopback or slave model on MISO)
// and a mode-3 loopback instance, with edge/window monitors on the SPI pins.
module tb_spi_master;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en0, en1;
    logic [7:0] din0, din1, dout0, dout1;
    logic       done0, done1, busy0, busy1, sclk0, sclk1;
    logic       mosi0, mosi1, miso0, miso1, cs_n0, cs_n1;
    logic       loop0;
    logic [7:0] slave_word;
    int         slave_idx = 0;

    int checks = 0;
    int errors = 0;

    spi_master #(.SPI_DATA_WIDTH(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0), .CS_IDLE_CYCLES(2)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en0), .i_data(din0), .o_data(dout0),
        .o_done(done0), .o_busy(busy0), .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso0), .o_cs_n(cs_n0)
    );

    spi_master #(.SPI_DATA_WIDTH(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .CS_IDLE_CYCLES(2)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en1), .i_data(din1), .o_data(dout1),
        .o_done(done1), .o_busy(busy1), .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso1), .o_cs_n(cs_n1)
    );

    // Mode-0 slave: MSB ready when cs_n falls, next bit after every falling SCLK.
    assign miso0 = loop0 ? mosi0 : ((slave_idx < 8) ? slave_word[3'(7 - slave_idx)] : 1'b0);
    assign miso1 = mosi1;

    always @(negedge sclk0 or posedge cs_n0) begin
        if (cs_n0) slave_idx <= 0;
        else       slave_idx <= slave_idx + 1;
    end

    int         edges0 = 0, edges_hi0 = 0, edges1 = 0, falls0 = 0, bad_mosi1 = 0;
    logic [7:0] cap0 = 8'h00, cap1 = 8'h00;
    logic       mosi1_q = 1'b0, sclk1_q = 1'b0;

    always @(sclk0) begin
        if (!cs_n0) edges0 <= edges0 + 1;
        else        edges_hi0 <= edges_hi0 + 1;
    end
    always @(sclk1) if (!cs_n1) edges1 <= edges1 + 1;
    always @(negedge cs_n0) falls0 <= falls0 + 1;
    always @(posedge sclk0) if (!cs_n0) cap0 <= {cap0[6:0], mosi0};
    always @(posedge sclk1) if (!cs_n1) cap1 <= {cap1[6:0], mosi1};
    always @(posedge clk) begin
        mosi1_q <= mosi1;
        sclk1_q <= sclk1;
    end
    // Mode 3: MOSI may only move in a cycle where SCLK went high -> low.
    always @(negedge clk) begin
        if (!cs_n1 && (mosi1 !== mosi1_q) && !(sclk1_q && !sclk1)) bad_mosi1 <= bad_mosi1 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         r_done_t, r_ndone, r_low;
    logic [7:0] r_rx;
    logic       r_cs_first, r_busy_first, r_mosi_first, r_sclk_lead, r_busy70, r_busy71;

    // Pulses enable for one cycle on the chosen instance and records timing for ncyc cycles.
    task automatic run_xfer(input int sel, input logic [7:0] d, input int ncyc);
        logic cs, dn, bz, mo, sc;
        logic [7:0] dq;
        if (sel == 0) begin din0 = d; en0 = 1'b1; end
        else          begin din1 = d; en1 = 1'b1; end
        step();
        en0 = 1'b0;
        en1 = 1'b0;
        r_done_t = -1; r_ndone = 0; r_low = 0; r_rx = 8'h00;
        r_cs_first = 1'b1; r_busy_first = 1'b0; r_mosi_first = 1'b0;
        r_sclk_lead = 1'b0; r_busy70 = 1'b0; r_busy71 = 1'b1;
        for (int t = 1; t <= ncyc; t++) begin
            cs = (sel == 0) ? cs_n0 : cs_n1;
            dn = (sel == 0) ? done0 : done1;
            bz = (sel == 0) ? busy0 : busy1;
            mo = (sel == 0) ? mosi0 : mosi1;
            sc = (sel == 0) ? sclk0 : sclk1;
            dq = (sel == 0) ? dout0 : dout1;
            if (t == 1) begin r_cs_first = cs; r_busy_first = bz; r_mosi_first = mo; end
            if (t == 4) r_sclk_lead = sc;
            if (t == 70) r_busy70 = bz;
            if (t == 71) r_busy71 = bz;
            if (!cs) r_low++;
            if (dn) begin
                r_ndone++;
                if (r_done_t < 0) begin r_done_t = t; r_rx = dq; end
            end
            step();
        end
        $display("xfer dut%0d tx=%02h rx=%02h done_at=N+%0d cs_low=%0d", sel, d, r_rx, r_done_t, r_low);
    endtask

    task automatic test_reset();
        checks++; if (cs_n0 !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b expected 1", cs_n0); end
        checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk0 got %b expected 0", sclk0); end
        checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL reset_sclk1 got %b expected 1", sclk1); end
        checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b expected 0", mosi0); end
        checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b expected 00", {busy0, done0}); end
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_data got %02h expected 00", dout0); end
        $display("reset: cs_n=%b sclk0=%b sclk1=%b busy=%b", cs_n0, sclk0, sclk1, busy0);
    endtask

    task automatic test_loopback();
        int e0, eh0;
        loop0 = 1'b1;
        e0 = edges0; eh0 = edges_hi0;
        run_xfer(0, 8'hA5, 75);
        checks++; if (r_cs_first !== 1'b0) begin errors++; $display("FAIL lb_cs_start got %b expected 0", r_cs_first); end
        checks++; if (r_busy_first !== 1'b1) begin errors++; $display("FAIL lb_busy_start got %b expected 1", r_busy_first); end
        checks++; if (r_mosi_first !== 1'b1) begin errors++; $display("FAIL lb_mosi_msb got %b expected 1", r_mosi_first); end
        checks++; if (r_sclk_lead !== 1'b0) begin errors++; $display("FAIL lb_sclk_lead got %b expected 0", r_sclk_lead); end
        checks++; if (r_done_t != 69) begin errors++; $display("FAIL lb_done_time got %0d expected 69", r_done_t); end
        checks++; if (r_ndone != 1) begin errors++; $display("FAIL lb_done_count got %0d expected 1", r_ndone); end
        checks++; if (r_low != 68) begin errors++; $display("FAIL lb_cs_low got %0d expected 68", r_low); end
        checks++; if (r_rx !== 8'hA5) begin errors++; $display("FAIL lb_data got %02h expected a5", r_rx); end
        checks++; if (edges0 - e0 != 16) begin errors++; $display("FAIL lb_edges got %0d expected 16", edges0 - e0); end
        checks++; if (edges_hi0 != eh0) begin errors++; $display("FAIL lb_edges_cs_high got %0d expected 0", edges_hi0 - eh0); end
        checks++; if (r_busy70 !== 1'b1) begin errors++; $display("FAIL lb_busy_gap got %b expected 1", r_busy70); end
        checks++; if (r_busy71 !== 1'b0) begin errors++; $display("FAIL lb_busy_end got %b expected 0", r_busy71); end
    endtask

    task automatic test_slave_word();
        loop0 = 1'b0;
        slave_word = 8'h3C;
        run_xfer(0, 8'hC3, 75);
        checks++; if (cap0 !== 8'hC3) begin errors++; $display("FAIL slv_mosi_stream got %02h expected c3", cap0); end
        checks++; if (r_rx !== 8'h3C) begin errors++; $display("FAIL slv_data got %02h expected 3c", r_rx); end
        checks++; if (r_done_t != 69) begin errors++; $display("FAIL slv_done_time got %0d expected 69", r_done_t); end
        loop0 = 1'b1;
    endtask

    task automatic test_driver_stream();
        logic [7:0] words [3] = '{8'h96, 8'h0F, 8'hE1};
        int wi = 0, nd = 0, f0 = falls0, hi_run = 0, min_gap = 1000;
        logic had_low = 1'b0, raise = 1'b0;
        din0 = words[0];
        en0 = 1'b1;
        for (int t = 0; t < 400; t++) begin
            step();
            if (raise) begin din0 = words[wi]; en0 = 1'b1; raise = 1'b0; end
            if (cs_n0) hi_run++;
            else begin
                if (had_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
                had_low = 1'b1;
            end
            if (done0) begin
                nd++;
                if (wi < 3) begin
                    checks++; if (dout0 !== words[wi]) begin errors++; $display("FAIL drv_data%0d got %02h expected %02h", wi, dout0, words[wi]); end
                    $display("xfer driver word%0d tx=%02h rx=%02h", wi, words[wi], dout0);
                end
                wi++;
                en0 = 1'b0;
                raise = (wi < 3);
            end
        end
        checks++; if (nd != 3) begin errors++; $display("FAIL drv_done_count got %0d expected 3", nd); end
        checks++; if (falls0 - f0 != 3) begin errors++; $display("FAIL drv_cs_windows got %0d expected 3", falls0 - f0); end
        checks++; if (min_gap < 2) begin errors++; $display("FAIL drv_min_gap got %0d expected >=2", min_gap); end
    endtask

    task automatic test_reset_midway();
        int e0 = edges0, nd = 0;
        bit reached = 0;
        din0 = 8'hF0;
        en0 = 1'b1;
        step();
        en0 = 1'b0;
        for (int t = 0; t < 100 && !reached; t++) begin
            if (done0) nd++;
            if (edges0 - e0 >= 5) reached = 1;
            else step();
        end
        checks++; if (!reached) begin errors++; $display("FAIL rst_wait_edge5 got timeout expected 5 edges"); end
        rst = 1'b1;
        step();
        checks++; if (cs_n0 !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n got %b expected 1", cs_n0); end
        checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk got %b expected 0", sclk0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy0); end
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %02h expected 00", dout0); end
        checks++; if (done0 !== 1'b0 || nd != 0) begin errors++; $display("FAIL rst_mid_done got %b/%0d expected 0", done0, nd); end
        rst = 1'b0;
        $display("xfer dut0 tx=f0 aborted by reset after 5 edges");
        step();
        run_xfer(0, 8'h5A, 75);
        checks++; if (r_rx !== 8'h5A) begin errors++; $display("FAIL rst_after_data got %02h expected 5a", r_rx); end
        checks++; if (r_done_t != 69) begin errors++; $display("FAIL rst_after_done_time got %0d expected 69", r_done_t); end
    endtask

    task automatic test_mode3();
        int e1 = edges1, b1 = bad_mosi1;
        checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got %b expected 1", sclk1); end
        run_xfer(1, 8'h81, 75);
        checks++; if (r_rx !== 8'h81) begin errors++; $display("FAIL m3_data got %02h expected 81", r_rx); end
        checks++; if (cap1 !== 8'h81) begin errors++; $display("FAIL m3_mosi_rising got %02h expected 81", cap1); end
        checks++; if (bad_mosi1 != b1) begin errors++; $display("FAIL m3_mosi_on_fall got %0d expected 0", bad_mosi1 - b1); end
        checks++; if (edges1 - e1 != 16) begin errors++; $display("FAIL m3_edges got %0d expected 16", edges1 - e1); end
        checks++; if (r_sclk_lead !== 1'b1) begin errors++; $display("FAIL m3_sclk_lead got %b expected 1", r_sclk_lead); end
        checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL m3_sclk_end got %b expected 1", sclk1); end
        checks++; if (r_done_t != 69) begin errors++; $display("FAIL m3_done_time got %0d expected 69", r_done_t); end
    endtask

    task automatic test_back_to_back();
        int nd = 0, phase = 0, gap = 0, f0 = falls0;
        loop0 = 1'b1;
        din0 = 8'h11;
        en0 = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            step();
            if (t == 10) din0 = 8'h22;
            if (done0) begin
                nd++;
                if (nd == 1) begin
                    checks++; if (cap0 !== 8'h11) begin errors++; $display("FAIL b2b_mosi1 got %02h expected 11", cap0); end
                    checks++; if (dout0 !== 8'h11) begin errors++; $display("FAIL b2b_data1 got %02h expected 11", dout0); end
                    phase = 1;
                end else if (nd == 2) begin
                    checks++; if (cap0 !== 8'h22) begin errors++; $display("FAIL b2b_mosi2 got %02h expected 22", cap0); end
                    checks++; if (dout0 !== 8'h22) begin errors++; $display("FAIL b2b_data2 got %02h expected 22", dout0); end
                    en0 = 1'b0;
                end
                $display("xfer back_to_back word%0d rx=%02h mosi=%02h", nd, dout0, cap0);
            end
            if (phase == 1) begin
                if (cs_n0) gap++;
                else phase = 2;
            end
        end
        checks++; if (gap != 2) begin errors++; $display("FAIL b2b_gap got %0d expected 2", gap); end
        checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d expected 2", nd); end
        checks++; if (falls0 - f0 != 2) begin errors++; $display("FAIL b2b_cs_windows got %0d expected 2", falls0 - f0); end
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0; en1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        loop0 = 1'b1;
        slave_word = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();
        test_reset();
        test_loopback();
        test_slave_word();
        test_driver_stream();
        test_reset_midway();
        test_mode3();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
